// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: decouples the I-cache from decode with a small FIFO.
// Accepts up to two instructions per cycle and presents up to two in first-word-fall-through order.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc1,
    input  logic [31:0]       in_pc2,
    input  logic [31:0]       in_inst1,
    input  logic [31:0]       in_inst2,
    input  logic              in_pred_taken1,
    input  logic              in_pred_taken2,
    input  logic [31:0]       in_pred_addr,
    output logic              fetch_stall,
    input  logic              dec_ready,
    output logic              out_valid1,
    output logic [31:0]       out_pc1,
    output logic [31:0]       out_inst1,
    output logic              out_pred_taken1,
    output logic [31:0]       out_pred_addr1,
    output logic              out_valid2,
    output logic [31:0]       out_pc2,
    output logic [31:0]       out_inst2,
    output logic              out_pred_taken2,
    output logic [31:0]       out_pred_addr2,
    output logic [PTR_W:0]    count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [CNT_W-1:0]   w_free;
    logic               w_stall;
    logic               w_push_en;
    logic [1:0]         w_push_n;
    logic [1:0]         w_pop_n;
    logic               w_valid1;
    logic               w_valid2;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [PTR_W-1:0]   w_rd_ptr1;
    entry_t             w_wr_ent1;
    entry_t             w_wr_ent2;
    entry_t             w_rd_ent1;
    entry_t             w_rd_ent2;

    // Back-pressure looks at occupancy only; a same-cycle pop does not free space early.
    assign w_free    = CNT_W'(DEPTH) - r_cnt;
    assign w_stall   = w_free < CNT_W'(2);
    assign w_push_en = in_valid & ~w_stall & ~flush;

    // A predicted-taken first instruction makes the second one wrong-path, so only one entry is written.
    assign w_push_n  = w_push_en ? (in_pred_taken1 ? 2'd1 : 2'd2) : 2'd0;

    assign w_valid1  = r_cnt != '0;
    assign w_valid2  = r_cnt >= CNT_W'(2);
    assign w_pop_n   = (dec_ready & ~flush) ? ({1'b0, w_valid1} + {1'b0, w_valid2}) : 2'd0;

    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

    always_comb begin
        w_wr_ent1        = '0;
        w_wr_ent2        = '0;
        w_wr_ent1.pc     = in_pc1;
        w_wr_ent1.inst   = in_inst1;
        w_wr_ent1.taken  = in_pred_taken1;
        w_wr_ent1.target = in_pred_taken1 ? in_pred_addr : 32'h0;
        w_wr_ent2.pc     = in_pc2;
        w_wr_ent2.inst   = in_inst2;
        w_wr_ent2.taken  = in_pred_taken2;
        w_wr_ent2.target = in_pred_taken2 ? in_pred_addr : 32'h0;
    end

    // Entry storage; flush only resets pointers, stale data is masked by the valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem <= '{default: '0};
        end else if (w_push_en) begin
            r_mem[r_wr_ptr] <= w_wr_ent1;
            if (!in_pred_taken1) begin
                r_mem[w_wr_ptr1] <= w_wr_ent2;
            end
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
            r_cnt    <= r_cnt + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
        end
    end

    assign w_rd_ent1 = w_valid1 ? r_mem[r_rd_ptr]  : '0;
    assign w_rd_ent2 = w_valid2 ? r_mem[w_rd_ptr1] : '0;

    assign out_valid1      = w_valid1;
    assign out_pc1         = w_rd_ent1.pc;
    assign out_inst1       = w_rd_ent1.inst;
    assign out_pred_taken1 = w_rd_ent1.taken;
    assign out_pred_addr1  = w_rd_ent1.target;

    assign out_valid2      = w_valid2;
    assign out_pc2         = w_rd_ent2.pc;
    assign out_inst2       = w_rd_ent2.inst;
    assign out_pred_taken2 = w_rd_ent2.taken;
    assign out_pred_addr2  = w_rd_ent2.target;

    assign count       = r_cnt;
    assign fetch_stall = w_stall;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized and directed bench for inst_fetch_buffer with a queue-based reference model.
// The model holds the expected FIFO contents; a negedge monitor compares the presented outputs.
module tb_inst_fetch_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc1, in_pc2, in_inst1, in_inst2, in_pred_addr;
    logic        in_pred_taken1, in_pred_taken2;
    logic        fetch_stall;
    logic        dec_ready;
    logic        out_valid1, out_valid2;
    logic [31:0] out_pc1, out_inst1, out_pred_addr1;
    logic [31:0] out_pc2, out_inst2, out_pred_addr2;
    logic        out_pred_taken1, out_pred_taken2;
    logic [PTR_W:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc1(in_pc1), .in_pc2(in_pc2), .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_pred_taken1(in_pred_taken1), .in_pred_taken2(in_pred_taken2),
        .in_pred_addr(in_pred_addr), .fetch_stall(fetch_stall), .dec_ready(dec_ready),
        .out_valid1(out_valid1), .out_pc1(out_pc1), .out_inst1(out_inst1),
        .out_pred_taken1(out_pred_taken1), .out_pred_addr1(out_pred_addr1),
        .out_valid2(out_valid2), .out_pc2(out_pc2), .out_inst2(out_inst2),
        .out_pred_taken2(out_pred_taken2), .out_pred_addr2(out_pred_addr2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] addr;
    } ent_t;

    ent_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of in-flight instructions.
    always @(posedge clk or negedge rst) begin
        int  n_pop;
        bit  stall;
        ent_t e;
        if (!rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            stall = (DEPTH - exp_q.size()) < 2;
            n_pop = dec_ready ? ((exp_q.size() >= 2) ? 2 : exp_q.size()) : 0;
            repeat (n_pop) void'(exp_q.pop_front());
            if (in_valid && !stall) begin
                e.pc = in_pc1; e.inst = in_inst1;
                e.taken = in_pred_taken1; e.addr = in_pred_taken1 ? in_pred_addr : 32'h0;
                exp_q.push_back(e);
                if (!in_pred_taken1) begin
                    e.pc = in_pc2; e.inst = in_inst2;
                    e.taken = in_pred_taken2; e.addr = in_pred_taken2 ? in_pred_addr : 32'h0;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compare what the DUT presents against the head of the model queue.
    always @(negedge clk) begin
        ent_t e1, e2;
        e1 = (exp_q.size() >= 1) ? exp_q[0] : '0;
        e2 = (exp_q.size() >= 2) ? exp_q[1] : '0;
        chk("sb_count", 32'(count), 32'(exp_q.size()));
        chk("sb_fetch_stall", 32'(fetch_stall), 32'((DEPTH - exp_q.size()) < 2));
        chk("sb_valid1", 32'(out_valid1), 32'(exp_q.size() >= 1));
        chk("sb_valid2", 32'(out_valid2), 32'(exp_q.size() >= 2));
        chk("sb_pc1", out_pc1, e1.pc);
        chk("sb_inst1", out_inst1, e1.inst);
        chk("sb_taken1", 32'(out_pred_taken1), 32'(e1.taken));
        chk("sb_addr1", out_pred_addr1, e1.addr);
        chk("sb_pc2", out_pc2, e2.pc);
        chk("sb_inst2", out_inst2, e2.inst);
        chk("sb_taken2", 32'(out_pred_taken2), 32'(e2.taken));
        chk("sb_addr2", out_pred_addr2, e2.addr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic v, input logic [31:0] pc1, input logic [31:0] i1,
                            input logic [31:0] pc2, input logic [31:0] i2,
                            input logic t1, input logic t2, input logic [31:0] addr);
        in_valid = v; in_pc1 = pc1; in_inst1 = i1; in_pc2 = pc2; in_inst2 = i2;
        in_pred_taken1 = t1; in_pred_taken2 = t2; in_pred_addr = addr;
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] base, exp_pc;
        rst = 1'b0; flush = 1'b0; dec_ready = 1'b1;
        set_pair(1'b1, 32'h1111_0000, 32'h2222_0000, 32'h1111_0004, 32'h2222_0004, 1'b0, 1'b1, 32'h3333_0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_valid2", 32'(out_valid2), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd0);
        chk("rst_pc1", out_pc1, 32'd0);
        chk("rst_addr2", out_pred_addr2, 32'd0);
        rst = 1'b1;
        in_valid = 1'b0; dec_ready = 1'b0;
        cyc();

        // Basic push
        set_pair(1'b1, 32'h1c00_0000, 32'h0280_0000, 32'h1c00_0004, 32'h0280_0400, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        chk("basic_count", 32'(count), 32'd2);
        chk("basic_pc1", out_pc1, 32'h1c00_0000);
        chk("basic_inst2", out_inst2, 32'h0280_0400);
        chk("basic_taken1", 32'(out_pred_taken1), 32'd0);
        do_flush();

        // Taken-first truncation, then taken-second
        set_pair(1'b1, 32'h1c00_0008, 32'h0280_0800, 32'h1c00_000c, 32'h0280_0c00, 1'b1, 1'b1, 32'h1c00_0100);
        cyc();
        in_valid = 1'b0;
        chk("tk1_count", 32'(count), 32'd1);
        chk("tk1_valid2", 32'(out_valid2), 32'd0);
        chk("tk1_addr1", out_pred_addr1, 32'h1c00_0100);
        do_flush();
        set_pair(1'b1, 32'h1c00_0010, 32'h0280_1000, 32'h1c00_0014, 32'h0280_1400, 1'b0, 1'b1, 32'h1c00_0200);
        cyc();
        in_valid = 1'b0;
        chk("tk2_count", 32'(count), 32'd2);
        chk("tk2_taken2", 32'(out_pred_taken2), 32'd1);
        chk("tk2_addr2", out_pred_addr2, 32'h1c00_0200);
        chk("tk2_addr1", out_pred_addr1, 32'd0);
        do_flush();

        // Fill to full, hold a fifth pair, then release one pop
        base = 32'h2000_0000;
        for (int k = 0; k < 4; k++) begin
            set_pair(1'b1, base + 32'(8*k), 32'hA000_0000 + 32'(k), base + 32'(8*k + 4),
                     32'hB000_0000 + 32'(k), 1'b0, 1'b0, 32'h0);
            cyc();
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_stall", 32'(fetch_stall), 32'd1);
        set_pair(1'b1, 32'hdead_0000, 32'hdead_0001, 32'hdead_0004, 32'hdead_0005, 1'b0, 1'b0, 32'h0);
        repeat (3) begin
            cyc();
            chk("hold_count", 32'(count), 32'd8);
            chk("hold_pc1", out_pc1, base);
        end
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0; in_valid = 1'b0;
        chk("release_count", 32'(count), 32'd6);
        chk("release_stall", 32'(fetch_stall), 32'd0);
        chk("release_pc1", out_pc1, base + 32'd8);
        do_flush();

        // Streaming across pointer wrap with decode always ready
        base = 32'h4000_0000;
        exp_pc = base;
        dec_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k < 20) set_pair(1'b1, base + 32'(8*k), 32'(k), base + 32'(8*k + 4), 32'(k + 100), 1'b0, 1'b0, 32'h0);
            else in_valid = 1'b0;
            if (out_valid1) begin chk("stream_pc1", out_pc1, exp_pc); exp_pc = exp_pc + 32'd4; end
            if (out_valid2) begin chk("stream_pc2", out_pc2, exp_pc); exp_pc = exp_pc + 32'd4; end
            chk("stream_count_le4", 32'(count <= 4), 32'd1);
            cyc();
        end
        chk("stream_total", exp_pc, base + 32'd160);
        chk("stream_empty", 32'(count), 32'd0);
        dec_ready = 1'b0;

        // Flush beats a same-cycle push and pop
        set_pair(1'b1, 32'h5000_0000, 32'h1, 32'h5000_0004, 32'h2, 1'b0, 1'b0, 32'h0);
        cyc();
        set_pair(1'b1, 32'h5000_0008, 32'h3, 32'h5000_000c, 32'h4, 1'b0, 1'b0, 32'h0);
        cyc();
        set_pair(1'b1, 32'h5000_0010, 32'h5, 32'h5000_0014, 32'h6, 1'b1, 1'b0, 32'h5000_0400);
        cyc();
        chk("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; dec_ready = 1'b1;
        set_pair(1'b1, 32'h5000_0018, 32'h7, 32'h5000_001c, 32'h8, 1'b0, 1'b0, 32'h0);
        cyc();
        flush = 1'b0; dec_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid1", 32'(out_valid1), 32'd0);
        set_pair(1'b1, 32'h6000_0000, 32'h9, 32'h6000_0004, 32'ha, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        chk("post_flush_pc1", out_pc1, 32'h6000_0000);

        // Random traffic, with one asynchronous reset mid-run
        for (int i = 0; i < 400; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_pc1         = $urandom; in_pc2   = $urandom;
            in_inst1       = $urandom; in_inst2 = $urandom;
            in_pred_addr   = $urandom;
            in_pred_taken1 = ($urandom_range(0, 3) == 0);
            in_pred_taken2 = ($urandom_range(0, 3) == 0);
            dec_ready      = ($urandom_range(0, 2) == 0);
            flush          = ($urandom_range(0, 15) == 0);
            if (i == 200) begin
                #2 rst = 1'b0;
                #4 rst = 1'b1;
            end
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; dec_ready = 1'b1;
        repeat (6) cyc();
        chk("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Decoupling FIFO directly downstream of the instruction cache.
- Each cycle it accepts up to two fetched instructions (pc, instruction word, branch-prediction info) when the cache reports a valid pair.
- The decode stage drains it at up to two instructions per cycle in first-word-fall-through order.
- It back-pressures fetch when fewer than two slots remain, and it empties on a pipeline flush (mispredict or exception).

Parameters:
DEPTH, 8, number of instruction entries; must be a power of two and at least 4.
PTR_W, 3, log2(DEPTH); width of the read and write pointers.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  discard all entries; takes priority over push and pop.
in_valid  input  1  the cache delivers a hit pair this cycle (the cache's inst_valid).
in_pc1  input  32  pc of the first instruction.
in_pc2  input  32  pc of the second instruction.
in_inst1  input  32  first instruction word.
in_inst2  input  32  second instruction word.
in_pred_taken1  input  1  predictor says the first instruction is a taken branch.
in_pred_taken2  input  1  predictor says the second instruction is a taken branch.
in_pred_addr  input  32  predicted target of the taken instruction.
fetch_stall  output  1  high when free slots < 2; fetch must hold its pair.
dec_ready  input  1  decode consumes all currently valid outputs this cycle.
out_valid1  output  1  head entry valid.
out_pc1  output  32  head entry pc.
out_inst1  output  32  head entry instruction.
out_pred_taken1  output  1  head entry predicted taken.
out_pred_addr1  output  32  head entry predicted target.
out_valid2  output  1  second entry valid.
out_pc2  output  32  second entry pc.
out_inst2  output  32  second entry instruction.
out_pred_taken2  output  1  second entry predicted taken.
out_pred_addr2  output  32  second entry predicted target.
count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Storage: DEPTH entries, each holding {pc[31:0], inst[31:0], taken, target[31:0]}. Pointers are wr_ptr and rd_ptr, PTR_W bits each, wrapping modulo DEPTH. The occupancy register cnt is PTR_W+1 bits.
- Reset (rst low, asynchronous):
  - wr_ptr = rd_ptr = cnt = 0.
  - All entries cleared to 0.
  - Outputs: out_valid1/2 = 0, all out_* data = 0, count = 0, fetch_stall = 0.
- fetch_stall = (DEPTH - cnt) < 2. It is combinational from cnt only; a same-cycle pop does not relieve it.
- Push condition: push_en = in_valid & ~fetch_stall & ~flush.
  - A pair arriving while fetch_stall is high is ignored; upstream must hold it.
- Push count:
  - in_pred_taken1 = 1: push 1 entry {in_pc1, in_inst1, 1, in_pred_addr}. The second instruction is wrong-path and is dropped; in_pred_taken2 is ignored.
  - Otherwise: push 2 entries at wr_ptr and wr_ptr+1: {in_pc1, in_inst1, 0, 0} and {in_pc2, in_inst2, in_pred_taken2, in_pred_taken2 ? in_pred_addr : 0}.
- Read side (first-word-fall-through, combinational from storage):
  - out_valid1 = cnt >= 1; out_valid2 = cnt >= 2.
  - out_*1 shows entry[rd_ptr]; out_*2 shows entry[rd_ptr+1].
  - Data outputs are driven to 0 when the corresponding valid is low.
- Pop: when dec_ready = 1 and flush = 0, pop_n = out_valid1 + out_valid2 (0, 1 or 2).
  - rd_ptr advances by pop_n.
  - dec_ready with cnt = 0 is a no-op.
- Occupancy update: cnt_next = cnt + push_n - pop_n, where push_n is 0, 1 or 2. Simultaneous push and pop in one cycle are both honoured. cnt never exceeds DEPTH, guaranteed by fetch_stall.
- Flush (synchronous, flush = 1 at a clock edge):
  - wr_ptr = rd_ptr = cnt = 0.
  - Any same-cycle push or pop is discarded.
  - Entries need not be cleared; outputs read invalid from the next cycle.
- Wrap-around: a pair starting at DEPTH-1 writes slots DEPTH-1 and 0. The pointer increment is modulo DEPTH.
- Latency: a pair pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Asynchronous reset mid-operation discards all contents. The first push after rst rises behaves as after power-up.

Test Plan:
1. Reset: hold rst=0 two cycles with in_valid=1 and dec_ready=1 -> count=0, out_valid1=out_valid2=0, fetch_stall=0, all out_* data=0.
2. Basic push: in_valid=1, pcs 0x1c000000/0x1c000004, insts 0x02800000/0x02800400, no taken, dec_ready=0 -> next cycle count=2, out_pc1=0x1c000000, out_inst2=0x02800400, out_pred_taken1=0.
3. Taken-first truncation: in_pred_taken1=1, in_pred_addr=0x1c000100 -> count=1, out_valid2=0, out_pred_addr1=0x1c000100. Taken-second case (in_pred_taken2=1 only) -> count=2, out_pred_taken2=1, out_pred_addr2=in_pred_addr, out_pred_addr1=0.
4. Full and back-pressure: four non-taken pairs, dec_ready=0 -> count=8, fetch_stall=1 after the 4th. A fifth pair held for 3 cycles -> count stays 8 and no entry is overwritten. dec_ready=1 for one cycle -> count=6, fetch_stall=0.
5. Wrap and ordering: stream 20 sequential pairs (pc step 8) with dec_ready=1 every cycle -> popped pcs strictly increase by 4 with no gaps or duplicates across pointer wrap. count never exceeds 4.
6. Flush priority: count=5, and in one cycle flush=1, in_valid=1, dec_ready=1 -> next cycle count=0, out_valid1=0. A push the following cycle appears at out_pc1 one cycle later.
